// File: rtl/except_ctrl_pkg.sv
// except_ctrl_pkg: shared cause codes, CP0 addresses, bus fields and FSM states for the MEM-stage exception arbiter.
package except_ctrl_pkg;
    localparam int STALL_W = 6;
    localparam logic STOP = 1'b1;
    localparam logic [31:0] EXC_NONE = 32'h0;
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'ha;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_TR   = 32'hd;
    localparam logic [31:0] EXC_ERET = 32'he;
    localparam logic [4:0] CP0_REG_STATUS = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_REG_EPC    = 5'd14;
    localparam int BUS_WE      = 37;
    localparam int BUS_ADDR_HI = 36;
    localparam int BUS_ADDR_LO = 32;
    localparam int BUS_DATA_HI = 31;
    localparam int FL_ADEL = 0;
    localparam int FL_ADES = 1;
    localparam int FL_RI   = 2;
    localparam int FL_SYS  = 3;
    localparam int FL_BRK  = 4;
    localparam int FL_TRAP = 5;
    localparam int FL_OV   = 6;
    localparam int FL_ERET = 7;
    typedef enum logic [1:0] {IDLE, FLUSH, BLOCK} state_t;
    typedef struct packed {
        logic [31:0] code;
        logic [31:0] bad_vaddr;
    } prio_t;
endpackage

// File: rtl/except_ctrl_prio.sv
// except_prio: combinational priority encoder turning exception flags and interrupt-pending into {code, bad_vaddr}.
module except_prio
    import except_ctrl_pkg::*;
(
    input  logic [7:0]  flags,
    input  logic        int_pending,
    input  logic        adel_if,
    input  logic [31:0] pc,
    input  logic [31:0] mem_vaddr,
    output prio_t       result
);
    logic pre_mem;
    assign pre_mem = flags[FL_RI] | flags[FL_SYS] | flags[FL_BRK] | flags[FL_TRAP] | flags[FL_OV];
    assign result.code = int_pending     ? EXC_INT  :
                         adel_if         ? EXC_ADEL :
                         flags[FL_RI]    ? EXC_RI   :
                         flags[FL_SYS]   ? EXC_SYS  :
                         flags[FL_BRK]   ? EXC_BP   :
                         flags[FL_TRAP]  ? EXC_TR   :
                         flags[FL_OV]    ? EXC_OV   :
                         flags[FL_ADEL]  ? EXC_ADEL :
                         flags[FL_ADES]  ? EXC_ADES :
                         flags[FL_ERET]  ? EXC_ERET : EXC_NONE;
    assign result.bad_vaddr = int_pending ? '0 :
                              adel_if     ? pc :
                              pre_mem     ? '0 :
                              (flags[FL_ADEL] | flags[FL_ADES]) ? mem_vaddr : '0;
endmodule

// File: rtl/except_ctrl.sv
// except_ctrl: MEM-stage exception arbiter feeding CP0, with registered flush/redirect and post-flush blocking.
// Optional EXC_COUNT_EN adds exc_cnt_o counting every accepted exception.
module except_ctrl
    import except_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          BLOCK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               mem_valid_i,
    input  logic [31:0]        pc_i,
    input  logic               is_in_delayslot_i,
    input  logic [7:0]         exc_flags_i,
    input  logic               adel_if_i,
    input  logic [31:0]        mem_vaddr_i,
    input  logic [31:0]        cp0_status_i,
    input  logic [31:0]        cp0_cause_i,
    input  logic [31:0]        cp0_epc_i,
    input  logic [37:0]        wb_cp0_bus_i,
    output logic [31:0]        excepttype_o,
    output logic [31:0]        pc_o,
    output logic [31:0]        bad_vaddr_o,
    output logic               is_in_delayslot_o,
    output logic               flush_o,
    output logic [31:0]        new_pc_o
`ifdef EXC_COUNT_EN
    ,
    output logic [31:0]        exc_cnt_o
`endif
);
    localparam logic [2:0] CNT_INIT = 3'(BLOCK_CYCLES - 1);
    state_t state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [4:0] bus_addr;
    logic [31:0] bus_data, status, cause, epc;
    logic int_pending, active, take;
    prio_t prio;
    logic unused;
    assign bus_addr = wb_cp0_bus_i[BUS_ADDR_HI:BUS_ADDR_LO];
    assign bus_data = wb_cp0_bus_i[BUS_DATA_HI:0];
    // Forward a same-cycle MTC0 so interrupt and ERET decisions see the newest value
    assign status = (wb_cp0_bus_i[BUS_WE] && bus_addr == CP0_REG_STATUS) ? bus_data : cp0_status_i;
    assign cause  = (wb_cp0_bus_i[BUS_WE] && bus_addr == CP0_REG_CAUSE)  ? bus_data : cp0_cause_i;
    assign epc    = (wb_cp0_bus_i[BUS_WE] && bus_addr == CP0_REG_EPC)    ? bus_data : cp0_epc_i;
    assign int_pending = |(cause[15:8] & status[15:8]) && status[0] && !status[1];
    assign unused = ^{stall[STALL_W-1:5], stall[3:0], status[31:16], status[7:2], cause[31:16], cause[7:0]};
    except_prio u_prio (
        .flags      (exc_flags_i),
        .int_pending(int_pending),
        .adel_if    (adel_if_i),
        .pc         (pc_i),
        .mem_vaddr  (mem_vaddr_i),
        .result     (prio)
    );
    assign active = mem_valid_i && stall[4] != STOP && state == IDLE && !rst;
    assign excepttype_o = active ? prio.code : '0;
    assign pc_o = active ? pc_i : '0;
    assign bad_vaddr_o = active ? prio.bad_vaddr : '0;
    assign is_in_delayslot_o = active && is_in_delayslot_i;
    assign take = excepttype_o != EXC_NONE;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        case (state)
            IDLE: state_n = take ? FLUSH : IDLE;
            FLUSH: begin
                cnt_n = CNT_INIT;
                state_n = (BLOCK_CYCLES == 1) ? IDLE : BLOCK;
            end
            default: begin
                cnt_n = cnt - 3'd1;
                state_n = (cnt <= 3'd1) ? IDLE : BLOCK;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            flush_o <= 1'b0;
            new_pc_o <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            flush_o <= take;
            if (take) new_pc_o <= (excepttype_o == EXC_ERET) ? epc : EXC_VECTOR;
        end
    end
`ifdef EXC_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) exc_cnt_o <= '0;
        else if (take) exc_cnt_o <= exc_cnt_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_except_ctrl.sv
// tb_except_ctrl: directed and randomized checks of except_ctrl against a cycle-level behavioural model.
module tb_except_ctrl;
    localparam int BC = 2;
    localparam logic [31:0] VEC = 32'hBFC00380;
    logic clk = 0, rst = 1;
    logic [5:0] stall;
    logic mem_valid, dslot, adel_if, flush;
    logic [31:0] pc, vaddr, status, cause, epc, etype, pc_out, bad_out, new_pc;
    logic [7:0] flags;
    logic [37:0] bus;
    logic dslot_out;
    logic [31:0] exc_cnt;
    int tests = 0, fails = 0;
    int sup = 0;
    logic m_flush = 0;
    logic [31:0] m_newpc = 0, m_cnt = 0;

    except_ctrl #(.EXC_VECTOR(VEC), .BLOCK_CYCLES(BC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .mem_valid_i(mem_valid), .pc_i(pc),
        .is_in_delayslot_i(dslot), .exc_flags_i(flags), .adel_if_i(adel_if), .mem_vaddr_i(vaddr),
        .cp0_status_i(status), .cp0_cause_i(cause), .cp0_epc_i(epc), .wb_cp0_bus_i(bus),
        .excepttype_o(etype), .pc_o(pc_out), .bad_vaddr_o(bad_out), .is_in_delayslot_o(dslot_out),
        .flush_o(flush), .new_pc_o(new_pc)
`ifdef EXC_COUNT_EN
        , .exc_cnt_o(exc_cnt)
`endif
    );
`ifndef EXC_COUNT_EN
    assign exc_cnt = m_cnt;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] eff(input logic [4:0] a, input logic [31:0] v);
        return (bus[37] && bus[36:32] == a) ? bus[31:0] : v;
    endfunction

    // Reference cause selection: walk the architectural priority list
    function automatic logic [63:0] ref_cause();
        logic [31:0] s, c;
        s = eff(5'd12, status);
        c = eff(5'd13, cause);
        if ((c[15:8] & s[15:8]) != 0 && s[0] && !s[1]) return {32'h1, 32'h0};
        if (adel_if) return {32'h4, pc};
        if (flags[2]) return {32'ha, 32'h0};
        if (flags[3]) return {32'h8, 32'h0};
        if (flags[4]) return {32'h9, 32'h0};
        if (flags[5]) return {32'hd, 32'h0};
        if (flags[6]) return {32'hc, 32'h0};
        if (flags[0]) return {32'h4, vaddr};
        if (flags[1]) return {32'h5, vaddr};
        if (flags[7]) return {32'he, 32'h0};
        return 64'h0;
    endfunction

    function automatic logic masked();
        return rst || !mem_valid || stall[4] || sup > 0;
    endfunction

    always @(posedge clk) begin
        logic [63:0] r;
        r = ref_cause();
        if (rst) begin
            sup = 0; m_flush = 0; m_newpc = 0; m_cnt = 0;
        end else if (!masked() && r[63:32] != 0) begin
            m_flush = 1;
            m_newpc = (r[63:32] == 32'he) ? eff(5'd14, epc) : VEC;
            sup = BC;
            m_cnt++;
        end else begin
            m_flush = 0;
            if (sup > 0) sup--;
        end
    end

    always @(negedge clk) begin
        logic [63:0] r;
        r = masked() ? 64'h0 : ref_cause();
        chk("excepttype", etype, r[63:32]);
        chk("pc_o", pc_out, masked() ? 32'h0 : pc);
        chk("bad_vaddr", bad_out, r[31:0]);
        chk("dslot", {31'h0, dslot_out}, {31'h0, !masked() && dslot});
        chk("flush", {31'h0, flush}, {31'h0, m_flush});
        chk("new_pc", new_pc, m_newpc);
        chk("exc_cnt", exc_cnt, m_cnt);
    end

    task automatic clear();
        stall = 0; mem_valid = 1; dslot = 0; adel_if = 0; flags = 0;
        pc = 0; vaddr = 0; status = 0; cause = 0; epc = 0; bus = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        clear();
        repeat (n) step();
    endtask

    initial begin
        clear();
        step(); step();
        @(negedge clk);
        chk("rst_flush", {31'h0, flush}, 32'h0);
        chk("rst_newpc", new_pc, 32'h0);
        step();
        rst = 0;
        idle(2);
        pc = 32'hBFC00100; flags = 8'h08;
        @(negedge clk);
        chk("sys_code", etype, 32'h8);
        chk("sys_pc", pc_out, 32'hBFC00100);
        step(); clear();
        @(negedge clk);
        chk("sys_flush", {31'h0, flush}, 32'h1);
        chk("sys_newpc", new_pc, 32'hBFC00380);
        step();
        @(negedge clk);
        chk("sys_flush_drop", {31'h0, flush}, 32'h0);
        idle(4);
        flags = 8'h01; vaddr = 32'h80000003; dslot = 1;
        @(negedge clk);
        chk("adel_code", etype, 32'h4);
        chk("adel_bad", bad_out, 32'h80000003);
        chk("adel_dslot", {31'h0, dslot_out}, 32'h1);
        idle(4);
        status = 32'h0000FF01; cause = 32'h00008000; flags = 8'h40;
        @(negedge clk);
        chk("int_over_ov", etype, 32'h1);
        idle(4);
        status = 32'h0000FF03; cause = 32'h00008000; flags = 8'h40;
        @(negedge clk);
        chk("ov_exl", etype, 32'hc);
        idle(4);
        epc = 32'h1000; bus = {1'b1, 5'd14, 32'h2000}; flags = 8'h80;
        @(negedge clk);
        chk("eret_code", etype, 32'he);
        step(); clear();
        @(negedge clk);
        chk("eret_newpc", new_pc, 32'h2000);
        idle(4);
        flags = 8'h08;
        @(negedge clk);
        chk("sys2_first", etype, 32'h8);
        step();
        @(negedge clk);
        chk("sys2_second", etype, 32'h0);
        chk("sys2_flush", {31'h0, flush}, 32'h1);
        step();
        @(negedge clk);
        chk("sys2_one_pulse", {31'h0, flush}, 32'h0);
        idle(4);
        flags = 8'h10; stall = 6'b010000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_code", etype, 32'h0);
            step();
        end
        stall = 0;
        @(negedge clk);
        chk("stall_release", etype, 32'h9);
        step(); clear();
        @(negedge clk);
        chk("stall_flush", {31'h0, flush}, 32'h1);
        idle(4);
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            stall = 6'($urandom) & (($urandom_range(0, 4) == 0) ? 6'h3f : 6'h2f);
            mem_valid = ($urandom_range(0, 7) != 0);
            dslot = 1'($urandom);
            adel_if = ($urandom_range(0, 15) == 0);
            flags = 8'($urandom) & 8'($urandom) & 8'($urandom);
            pc = $urandom; vaddr = $urandom; epc = $urandom;
            status = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
            cause = {16'h0, 8'($urandom) & 8'($urandom), 8'h0};
            bus = {1'($urandom), 5'($urandom_range(11, 15)), 32'($urandom)};
            step();
        end
        rst = 0; idle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
